bp_be_mmu_cmd_arb: RTL and testbench



---
 rtl/bp_be_mmu_cmd_arb_if.sv | 38 +++
 rtl/bp_be_mmu_cmd_arb.sv | 114 +++++++++++
 tb/tb_bp_be_mmu_cmd_arb.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/bp_be_mmu_cmd_arb_if.sv
// MMU command arbiter bus bundle.
// Pipe and PTW request channels, MMU command channel and response flags.
interface bp_be_mmu_cmd_arb_if #(
    parameter int cmd_width_p = 128
);
    logic [cmd_width_p-1:0] pipe_cmd_i;
    logic                   pipe_cmd_v_i;
    logic                   pipe_cmd_ready_o;
    logic                   pipe_kill_i;
    logic [cmd_width_p-1:0] ptw_cmd_i;
    logic                   ptw_cmd_v_i;
    logic                   ptw_cmd_ready_o;
    logic [cmd_width_p-1:0] mmu_cmd_o;
    logic                   mmu_cmd_v_o;
    logic                   mmu_cmd_ready_i;
    logic                   mem_resp_v_i;
    logic                   resp_pipe_v_o;
    logic                   resp_ptw_v_o;
    logic                   busy_o;

    modport slave (
        input  pipe_cmd_i, pipe_cmd_v_i, pipe_kill_i,
        input  ptw_cmd_i, ptw_cmd_v_i,
        input  mmu_cmd_ready_i, mem_resp_v_i,
        output pipe_cmd_ready_o, ptw_cmd_ready_o,
        output mmu_cmd_o, mmu_cmd_v_o,
        output resp_pipe_v_o, resp_ptw_v_o, busy_o
    );

    modport master (
        output pipe_cmd_i, pipe_cmd_v_i, pipe_kill_i,
        output ptw_cmd_i, ptw_cmd_v_i,
        output mmu_cmd_ready_i, mem_resp_v_i,
        input  pipe_cmd_ready_o, ptw_cmd_ready_o,
        input  mmu_cmd_o, mmu_cmd_v_o,
        input  resp_pipe_v_o, resp_ptw_v_o, busy_o
    );
endinterface

// File: rtl/bp_be_mmu_cmd_arb.sv
// Two-requester MMU command arbiter with starvation guard.
// One command outstanding; pipe-owned commands can be killed in flight.
module bp_be_mmu_cmd_arb #(
    parameter int cmd_width_p    = 128,
    parameter int starve_limit_p = 4,
    parameter int cnt_width_p    = 3
) (
    input logic clk_i,
    input logic reset_i,
    bp_be_mmu_cmd_arb_if.slave bus
);
    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_RESP = 1'b1
    } state_e;

    localparam logic [cnt_width_p-1:0] limit =
        cnt_width_p'(starve_limit_p);

    state_e state;
    state_e state_n;
    logic owner;
    logic killed;
    logic [cnt_width_p-1:0] starve_cnt;

    logic idle;
    logic starved;
    logic ptw_win;
    logic pipe_win;
    logic pipe_hs;
    logic ptw_hs;

    assign idle     = (state == IDLE);
    assign starved  = (starve_cnt == limit);
    assign ptw_win  = bus.ptw_cmd_v_i
                    & (~bus.pipe_cmd_v_i | starved);
    assign pipe_win = bus.pipe_cmd_v_i & ~ptw_win;
    assign pipe_hs  = idle & pipe_win & bus.mmu_cmd_ready_i;
    assign ptw_hs   = idle & ptw_win & bus.mmu_cmd_ready_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state: grant leaves IDLE, response returns to it.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (pipe_hs | ptw_hs) begin
                    state_n = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (bus.mem_resp_v_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs: grant mux, readies, response steering.
    // Responses are suppressed during reset so a dropped
    // command never reports back.
    always_comb begin
        bus.mmu_cmd_v_o      = idle
                             & (bus.pipe_cmd_v_i | bus.ptw_cmd_v_i);
        bus.mmu_cmd_o        = '0;
        if (ptw_win) begin
            bus.mmu_cmd_o    = bus.ptw_cmd_i;
        end else if (pipe_win) begin
            bus.mmu_cmd_o    = bus.pipe_cmd_i;
        end
        bus.pipe_cmd_ready_o = pipe_hs;
        bus.ptw_cmd_ready_o  = ptw_hs;
        bus.resp_pipe_v_o    = bus.mem_resp_v_i & ~idle & ~owner
                             & ~killed & ~bus.pipe_kill_i
                             & ~reset_i;
        bus.resp_ptw_v_o     = bus.mem_resp_v_i & ~idle & owner
                             & ~reset_i;
        bus.busy_o           = ~idle;
    end

    // Owner and kill tracking for the outstanding command.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            owner  <= 1'b0;
            killed <= 1'b0;
        end else if (pipe_hs | ptw_hs) begin
            owner  <= ptw_hs;
            killed <= 1'b0;
        end else if (~idle & ~owner & bus.pipe_kill_i) begin
            killed <= 1'b1;
        end
    end

    // Starvation counter: counts PTW losses, clears on PTW grant.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_cnt <= '0;
        end else if (ptw_hs) begin
            starve_cnt <= '0;
        end else if (idle & bus.ptw_cmd_v_i & bus.mmu_cmd_ready_i
                     & pipe_win & ~starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_bp_be_mmu_cmd_arb.sv
// Directed bench for the MMU command arbiter.
// Expected owners are queued at grant and checked at response.
module tb_bp_be_mmu_cmd_arb;
    localparam int W = 128;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic reset_i;

    always #5 clk = ~clk;

    bp_be_mmu_cmd_arb_if #(.cmd_width_p(W)) bus ();

    bp_be_mmu_cmd_arb #(
        .cmd_width_p(W),
        .starve_limit_p(LIM),
        .cnt_width_p(3)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    bit sb[$];

    task automatic chk(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.pipe_cmd_i      = '0;
        bus.pipe_cmd_v_i    = 1'b0;
        bus.pipe_kill_i     = 1'b0;
        bus.ptw_cmd_i       = '0;
        bus.ptw_cmd_v_i     = 1'b0;
        bus.mmu_cmd_ready_i = 1'b0;
        bus.mem_resp_v_i    = 1'b0;
    endtask

    task automatic do_grant(input bit pv, input bit tv);
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit w;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        bus.pipe_cmd_i      = a;
        bus.ptw_cmd_i       = b;
        bus.pipe_cmd_v_i    = pv;
        bus.ptw_cmd_v_i     = tv;
        bus.mmu_cmd_ready_i = 1'b1;
        w = tv && (!pv || model_cnt == LIM);
        @(negedge clk);
        chk("grant_v", bus.mmu_cmd_v_o, 1);
        chk("grant_cmd", bus.mmu_cmd_o, w ? b : a);
        chk("grant_pipe_rdy", bus.pipe_cmd_ready_o, !w);
        chk("grant_ptw_rdy", bus.ptw_cmd_ready_o, w);
        sb.push_back(w);
        if (w) model_cnt = 0;
        else if (tv && model_cnt < LIM) model_cnt++;
        step();
        bus.pipe_cmd_v_i = 1'b0;
        bus.ptw_cmd_v_i  = 1'b0;
    endtask

    task automatic wait_cyc(input bit kill);
        bus.pipe_kill_i = kill;
        @(negedge clk);
        chk("wait_busy", bus.busy_o, 1);
        chk("wait_resp_pipe", bus.resp_pipe_v_o, 0);
        chk("wait_resp_ptw", bus.resp_ptw_v_o, 0);
        step();
        bus.pipe_kill_i = 1'b0;
    endtask

    task automatic do_resp(input bit kill, input bit killed);
        bit w;
        bus.mem_resp_v_i = 1'b1;
        bus.pipe_kill_i  = kill;
        bus.pipe_cmd_v_i = 1'b1;
        bus.ptw_cmd_v_i  = 1'b1;
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            w = sb.pop_front();
            chk("resp_pipe", bus.resp_pipe_v_o,
                !w && !killed && !kill);
            chk("resp_ptw", bus.resp_ptw_v_o, w);
        end
        chk("resp_busy", bus.busy_o, 1);
        chk("resp_no_grant", bus.mmu_cmd_v_o, 0);
        chk("resp_pipe_rdy", bus.pipe_cmd_ready_o, 0);
        step();
        bus.mem_resp_v_i = 1'b0;
        bus.pipe_kill_i  = 1'b0;
        bus.pipe_cmd_v_i = 1'b0;
        bus.ptw_cmd_v_i  = 1'b0;
        @(negedge clk);
        chk("post_resp_busy", bus.busy_o, 0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=done");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        reset_i = 1'b1;
        bus.pipe_cmd_i      = 128'h1234;
        bus.pipe_cmd_v_i    = 1'b1;
        bus.mmu_cmd_ready_i = 1'b1;
        bus.mem_resp_v_i    = 1'b1;
        step();
        @(negedge clk);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_comb_rdy", bus.pipe_cmd_ready_o, 1);
        chk("rst_comb_cmd", bus.mmu_cmd_o, 128'h1234);
        chk("rst_resp_pipe", bus.resp_pipe_v_o, 0);
        chk("rst_resp_ptw", bus.resp_ptw_v_o, 0);
        step();
        clear_inputs();
        reset_i = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", bus.busy_o, 0);
        chk("post_rst_v", bus.mmu_cmd_v_o, 0);
        chk("post_rst_cmd", bus.mmu_cmd_o, 0);
        step();

        do_grant(1, 1);
        do_resp(0, 0);
        do_grant(0, 1);
        do_resp(0, 0);

        for (int i = 0; i < LIM; i++) begin
            do_grant(1, 1);
            do_resp(0, 0);
            if (i == 2) begin
                bus.pipe_cmd_v_i    = 1'b1;
                bus.ptw_cmd_v_i     = 1'b1;
                bus.mmu_cmd_ready_i = 1'b0;
                @(negedge clk);
                chk("stall_v", bus.mmu_cmd_v_o, 1);
                chk("stall_pipe_rdy", bus.pipe_cmd_ready_o, 0);
                chk("stall_ptw_rdy", bus.ptw_cmd_ready_o, 0);
                step();
                bus.pipe_cmd_v_i = 1'b0;
                bus.ptw_cmd_v_i  = 1'b0;
                @(negedge clk);
                chk("stall_busy", bus.busy_o, 0);
                step();
            end
        end
        do_grant(1, 1);
        do_resp(0, 0);
        do_grant(1, 1);
        do_resp(0, 0);

        do_grant(1, 0);
        wait_cyc(0);
        wait_cyc(1);
        do_resp(0, 1);

        do_grant(1, 0);
        do_resp(1, 0);

        do_grant(0, 1);
        do_resp(1, 0);

        bus.pipe_kill_i = 1'b1;
        do_grant(1, 0);
        bus.pipe_kill_i = 1'b0;
        do_resp(0, 0);

        bus.mem_resp_v_i = 1'b1;
        @(negedge clk);
        chk("idle_resp_pipe", bus.resp_pipe_v_o, 0);
        chk("idle_resp_ptw", bus.resp_ptw_v_o, 0);
        step();
        bus.mem_resp_v_i = 1'b0;
        @(negedge clk);
        chk("idle_resp_busy", bus.busy_o, 0);
        step();

        do_grant(1, 0);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        void'(sb.pop_front());
        model_cnt = 0;
        bus.mem_resp_v_i = 1'b1;
        @(negedge clk);
        chk("rst_drop_pipe", bus.resp_pipe_v_o, 0);
        chk("rst_drop_ptw", bus.resp_ptw_v_o, 0);
        chk("rst_drop_busy", bus.busy_o, 0);
        step();
        bus.mem_resp_v_i = 1'b0;

        chk("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
